// File: rtl/issue_pipe.sv
// issue_pipe: registered issue stage between the reservation station and the
// functional units. Each lane reads its operands (zero register, CDB bypass,
// register file), then captures the packet into a one-entry output slot.
//
// Handshake: on either side, a transfer happens in a cycle where valid and
// ready are both 1 at the rising edge. rs_ready depends only on squash,
// fu_ready and the slot state, and never on rs_in. fu_out holds steady while
// valid=1 and fu_ready=0.
module issue_pipe #(
  parameter int WAYS       = 3,
  parameter int XLEN       = 32,
  parameter int N_PHYS_REG = 64,
  parameter int N_CDB      = 3,
  parameter int ZERO_PR    = 0,
  parameter int COUNT_W    = 32,
  localparam int PR_W      = $clog2(N_PHYS_REG),
  localparam int CTRL_W    = 67,
  localparam int RS_W      = 1 + 2*XLEN + 3*PR_W + CTRL_W,
  localparam int FU_W      = 1 + 4*XLEN + PR_W + CTRL_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [WAYS*RS_W-1:0]       rs_in,
  output logic [WAYS-1:0]            rs_ready,
  input  logic [N_PHYS_REG*XLEN-1:0] physical_register,
  input  logic [N_CDB-1:0]           cdb_valid,
  input  logic [N_CDB*PR_W-1:0]      cdb_pr_idx,
  input  logic [N_CDB*XLEN-1:0]      cdb_value,
  output logic [WAYS*FU_W-1:0]       fu_out,
  input  logic [WAYS-1:0]            fu_ready,
  output logic [COUNT_W-1:0]         issue_count
);

  typedef struct packed {
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc;
    logic [PR_W-1:0] reg1_pr_idx;
    logic [PR_W-1:0] reg2_pr_idx;
    logic [1:0]      opa_select;
    logic [1:0]      opb_select;
    logic [3:0]      op_sel;
    logic [2:0]      fu_sel;
    logic [4:0]      alu_func;
    logic [1:0]      mult_func;
    logic [31:0]     inst;
    logic [PR_W-1:0] pr_idx;
    logic [4:0]      ar_idx;
    logic [4:0]      rob_idx;
    logic            rd_mem;
    logic            wr_mem;
    logic            cond_branch;
    logic            uncond_branch;
    logic            halt;
    logic            illegal;
    logic            csr_op;
    logic            valid;
  } rs_packet_t;

  typedef struct packed {
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [1:0]      opa_select;
    logic [1:0]      opb_select;
    logic [3:0]      op_sel;
    logic [2:0]      fu_select;
    logic [4:0]      alu_func;
    logic [1:0]      mult_func;
    logic [31:0]     inst;
    logic [PR_W-1:0] pr_idx;
    logic [4:0]      ar_idx;
    logic [4:0]      rob_idx;
    logic            rd_mem;
    logic            wr_mem;
    logic            cond_branch;
    logic            uncond_branch;
    logic            halt;
    logic            illegal;
    logic            csr_op;
    logic            valid;
  } fu_packet_t;

  // Per-lane slot state; the FULL/EMPTY state is what fu_out[i].valid shows.
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_state_t;

  localparam int SUM_W = COUNT_W + 8;

  rs_packet_t [WAYS-1:0] rs_pkt;
  fu_packet_t [WAYS-1:0] fu_pkt;
  fu_packet_t            load_pkt  [WAYS];
  fu_packet_t            payload_q [WAYS];
  slot_state_t           state_q   [WAYS];
  slot_state_t           state_d   [WAYS];
  logic [WAYS-1:0]       accept;
  logic [WAYS-1:0]       handshake;
  logic [SUM_W-1:0]      hs_total;
  logic [SUM_W-1:0]      sum_wide;
  logic [COUNT_W-1:0]    count_d;

  assign rs_pkt = rs_in;
  assign fu_out = fu_pkt;

  // Operand source: zero register, then lowest-numbered matching CDB port,
  // then the register file.
  function automatic logic [XLEN-1:0] read_operand(input logic [PR_W-1:0] idx);
    logic [XLEN-1:0] val;
    val = '0;
    if (idx != PR_W'(ZERO_PR)) begin
      val = physical_register[int'(idx)*XLEN +: XLEN];
      for (int k = N_CDB - 1; k >= 0; k--) begin
        if (cdb_valid[k] && (cdb_pr_idx[k*PR_W +: PR_W] == idx)) begin
          val = cdb_value[k*XLEN +: XLEN];
        end
      end
    end
    return val;
  endfunction

  // Lane readiness, accept and FU handshake strobes.
  always_comb begin
    rs_ready  = '0;
    accept    = '0;
    handshake = '0;
    for (int i = 0; i < WAYS; i++) begin
      rs_ready[i]  = !squash && ((state_q[i] == S_EMPTY) || fu_ready[i]);
      accept[i]    = rs_pkt[i].valid && rs_ready[i];
      handshake[i] = (state_q[i] == S_FULL) && fu_ready[i];
    end
  end

  // Slot next state: squash empties, accept fills, lone handshake drains.
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      state_d[i] = state_q[i];
      if (squash) begin
        state_d[i] = S_EMPTY;
      end else if (accept[i]) begin
        state_d[i] = S_FULL;
      end else if (handshake[i]) begin
        state_d[i] = S_EMPTY;
      end
    end
  end

  // Slot state register.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WAYS; i++) begin
      if (!reset) begin
        state_q[i] <= S_EMPTY;
      end else begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Build the outgoing packet: field copy plus operand read at accept time.
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      load_pkt[i]               = '0;
      load_pkt[i].npc           = rs_pkt[i].npc;
      load_pkt[i].pc            = rs_pkt[i].pc;
      load_pkt[i].rs1_value     = read_operand(rs_pkt[i].reg1_pr_idx);
      load_pkt[i].rs2_value     = read_operand(rs_pkt[i].reg2_pr_idx);
      load_pkt[i].opa_select    = rs_pkt[i].opa_select;
      load_pkt[i].opb_select    = rs_pkt[i].opb_select;
      load_pkt[i].op_sel        = rs_pkt[i].op_sel;
      load_pkt[i].fu_select     = rs_pkt[i].fu_sel;
      load_pkt[i].alu_func      = rs_pkt[i].alu_func;
      load_pkt[i].mult_func     = rs_pkt[i].mult_func;
      load_pkt[i].inst          = rs_pkt[i].inst;
      load_pkt[i].pr_idx        = rs_pkt[i].pr_idx;
      load_pkt[i].ar_idx        = rs_pkt[i].ar_idx;
      load_pkt[i].rob_idx       = rs_pkt[i].rob_idx;
      load_pkt[i].rd_mem        = rs_pkt[i].rd_mem;
      load_pkt[i].wr_mem        = rs_pkt[i].wr_mem;
      load_pkt[i].cond_branch   = rs_pkt[i].cond_branch;
      load_pkt[i].uncond_branch = rs_pkt[i].uncond_branch;
      load_pkt[i].halt          = rs_pkt[i].halt;
      load_pkt[i].illegal       = rs_pkt[i].illegal;
      load_pkt[i].csr_op        = rs_pkt[i].csr_op;
      load_pkt[i].valid         = 1'b1;
    end
  end

  // Payload register: loads only on accept, so an empty slot keeps old fields.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WAYS; i++) begin
      if (!reset) begin
        payload_q[i] <= '0;
      end else if (accept[i]) begin
        payload_q[i] <= load_pkt[i];
      end
    end
  end

  // Output view: held payload with valid taken from the slot state.
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      fu_pkt[i]       = payload_q[i];
      fu_pkt[i].valid = (state_q[i] == S_FULL);
    end
  end

  // Saturating sum of this cycle's handshakes onto the running count.
  always_comb begin
    hs_total = '0;
    for (int i = 0; i < WAYS; i++) begin
      hs_total = hs_total + SUM_W'(handshake[i]);
    end
    sum_wide = SUM_W'(issue_count) + hs_total;
    if (sum_wide > SUM_W'({COUNT_W{1'b1}})) begin
      count_d = '1;
    end else begin
      count_d = sum_wide[COUNT_W-1:0];
    end
  end

  // Issue statistics counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      issue_count <= '0;
    end else begin
      issue_count <= count_d;
    end
  end

endmodule

// File: tb/tb_issue_pipe.sv
// tb_issue_pipe: directed bench for issue_pipe. A second instance with a
// 4-bit counter shares all inputs so counter saturation can be observed.
module tb_issue_pipe;

  localparam int WAYS = 3;
  localparam int XLEN = 32;
  localparam int NPR  = 64;
  localparam int NCDB = 3;
  localparam int PR_W = 6;

  typedef struct packed {
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc;
    logic [PR_W-1:0] reg1_pr_idx;
    logic [PR_W-1:0] reg2_pr_idx;
    logic [1:0]      opa_select;
    logic [1:0]      opb_select;
    logic [3:0]      op_sel;
    logic [2:0]      fu_sel;
    logic [4:0]      alu_func;
    logic [1:0]      mult_func;
    logic [31:0]     inst;
    logic [PR_W-1:0] pr_idx;
    logic [4:0]      ar_idx;
    logic [4:0]      rob_idx;
    logic            rd_mem;
    logic            wr_mem;
    logic            cond_branch;
    logic            uncond_branch;
    logic            halt;
    logic            illegal;
    logic            csr_op;
    logic            valid;
  } rs_t;

  typedef struct packed {
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [1:0]      opa_select;
    logic [1:0]      opb_select;
    logic [3:0]      op_sel;
    logic [2:0]      fu_select;
    logic [4:0]      alu_func;
    logic [1:0]      mult_func;
    logic [31:0]     inst;
    logic [PR_W-1:0] pr_idx;
    logic [4:0]      ar_idx;
    logic [4:0]      rob_idx;
    logic            rd_mem;
    logic            wr_mem;
    logic            cond_branch;
    logic            uncond_branch;
    logic            halt;
    logic            illegal;
    logic            csr_op;
    logic            valid;
  } fu_t;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic                        squash;
  rs_t [WAYS-1:0]              rs_pkt;
  logic [WAYS-1:0]             rs_ready;
  logic [WAYS-1:0]             rs_ready_sat;
  logic [NPR-1:0][XLEN-1:0]    prf;
  logic [NCDB-1:0]             cdb_valid;
  logic [NCDB-1:0][PR_W-1:0]   cdb_pr_idx;
  logic [NCDB-1:0][XLEN-1:0]   cdb_value;
  fu_t [WAYS-1:0]              fu_out;
  fu_t [WAYS-1:0]              fu_out_sat;
  logic [WAYS-1:0]             fu_ready;
  logic [31:0]                 issue_count;
  logic [3:0]                  count_sat;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  issue_pipe dut (
    .clock(clock), .reset(reset), .squash(squash),
    .rs_in(rs_pkt), .rs_ready(rs_ready),
    .physical_register(prf),
    .cdb_valid(cdb_valid), .cdb_pr_idx(cdb_pr_idx), .cdb_value(cdb_value),
    .fu_out(fu_out), .fu_ready(fu_ready), .issue_count(issue_count)
  );

  issue_pipe #(.COUNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .squash(squash),
    .rs_in(rs_pkt), .rs_ready(rs_ready_sat),
    .physical_register(prf),
    .cdb_valid(cdb_valid), .cdb_pr_idx(cdb_pr_idx), .cdb_value(cdb_value),
    .fu_out(fu_out_sat), .fu_ready(fu_ready), .issue_count(count_sat)
  );

  // scoreboard compare
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: advance one edge, land 1 time unit after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic rs_t make_rs(input logic [31:0] pc, input logic [5:0] r1, input logic [5:0] r2);
    rs_t p;
    p               = '0;
    p.npc           = pc + 32'd4;
    p.pc            = pc;
    p.reg1_pr_idx   = r1;
    p.reg2_pr_idx   = r2;
    p.opa_select    = pc[1:0];
    p.opb_select    = pc[3:2];
    p.op_sel        = pc[7:4];
    p.fu_sel        = pc[2:0];
    p.alu_func      = pc[8:4];
    p.mult_func     = pc[5:4];
    p.inst          = pc ^ 32'hA5A5_0F0F;
    p.pr_idx        = pc[5:0];
    p.ar_idx        = ~pc[4:0];
    p.rob_idx       = pc[8:4];
    p.rd_mem        = pc[0];
    p.wr_mem        = pc[1];
    p.cond_branch   = pc[2];
    p.uncond_branch = pc[3];
    p.halt          = pc[4];
    p.illegal       = pc[5];
    p.csr_op        = pc[6];
    p.valid         = 1'b1;
    return p;
  endfunction

  // Compare a held lane packet against what make_rs(pc) plus operands implies.
  task automatic check_pkt(input int lane, input string tag, input logic [31:0] pc,
                           input logic [31:0] v1, input logic [31:0] v2);
    fu_t f;
    f = fu_out[lane];
    check($sformatf("%s_valid", tag), f.valid, 1);
    check($sformatf("%s_pc", tag), f.pc, pc);
    check($sformatf("%s_npc", tag), f.npc, pc + 32'd4);
    check($sformatf("%s_rs1", tag), f.rs1_value, v1);
    check($sformatf("%s_rs2", tag), f.rs2_value, v2);
    check($sformatf("%s_ctrl", tag),
          {f.opa_select, f.opb_select, f.op_sel, f.fu_select, f.alu_func, f.mult_func},
          {pc[1:0], pc[3:2], pc[7:4], pc[2:0], pc[8:4], pc[5:4]});
    check($sformatf("%s_inst", tag), f.inst, pc ^ 32'hA5A5_0F0F);
    check($sformatf("%s_idx", tag), {f.pr_idx, f.ar_idx, f.rob_idx},
          {pc[5:0], ~pc[4:0], pc[8:4]});
    check($sformatf("%s_flags", tag),
          {f.rd_mem, f.wr_mem, f.cond_branch, f.uncond_branch, f.halt, f.illegal, f.csr_op},
          {pc[0], pc[1], pc[2], pc[3], pc[4], pc[5], pc[6]});
  endtask

  function automatic logic [31:0] prf_val(input int r);
    return prf[r];
  endfunction

  initial begin
    reset      = 1'b0;
    squash     = 1'b0;
    rs_pkt     = '0;
    fu_ready   = '0;
    cdb_valid  = '0;
    cdb_pr_idx = '0;
    cdb_value  = '0;
    for (int r = 0; r < NPR; r++) prf[r] = 32'h5000_0000 + r;
    prf[0] = 32'hDEAD_BEEF;
    prf[5] = 32'h0000_1234;
    prf[7] = 32'h0000_AAAA;
    prf[9] = 32'h0000_9999;

    // reset: request on lane1 must be dropped
    rs_pkt[1] = make_rs(32'h0000_0F35, 6'd5, 6'd7);
    #1;
    check("rst_ready", rs_ready, 3'b111);
    step();
    step();
    for (int l = 0; l < WAYS; l++) check($sformatf("rst_valid%0d", l), fu_out[l].valid, 0);
    check("rst_zero", {63'd0, |fu_out}, 0);
    check("rst_count", issue_count, 0);
    check("rst_count_sat", count_sat, 0);

    // single issue; zero register ignores a CDB on tag 0
    reset      = 1'b1;
    rs_pkt     = '0;
    rs_pkt[0]  = make_rs(32'h0000_01B5, 6'd5, 6'd0);
    cdb_valid  = 3'b001;
    cdb_pr_idx[0] = 6'd0;
    cdb_value[0]  = 32'h55;
    #1;
    check("single_ready", rs_ready[0], 1);
    step();
    check_pkt(0, "single", 32'h0000_01B5, 32'h1234, 32'h0);
    rs_pkt[0].valid = 1'b0;
    cdb_valid = '0;
    fu_ready  = 3'b001;
    step();
    check("single_count", issue_count, 1);
    check("single_drain", fu_out[0].valid, 0);
    fu_ready = '0;

    // bypass priority
    rs_pkt[0] = make_rs(32'h0000_02CA, 6'd7, 6'd9);
    cdb_valid = 3'b101;
    cdb_pr_idx[0] = 6'd7; cdb_value[0] = 32'h11;
    cdb_pr_idx[1] = 6'd9; cdb_value[1] = 32'h33;
    cdb_pr_idx[2] = 6'd7; cdb_value[2] = 32'h22;
    step();
    check_pkt(0, "byp_low", 32'h0000_02CA, 32'h11, 32'h9999);
    rs_pkt[0] = make_rs(32'h0000_03E7, 6'd7, 6'd9);
    cdb_valid = 3'b100;
    fu_ready  = 3'b001;
    #1;
    check("b2b_ready", rs_ready[0], 1);
    step();
    check_pkt(0, "byp_hi", 32'h0000_03E7, 32'h22, 32'h9999);
    check("byp_count2", issue_count, 2);
    rs_pkt[0] = make_rs(32'h0000_04D9, 6'd7, 6'd9);
    cdb_valid = 3'b010;
    step();
    check_pkt(0, "byp_none", 32'h0000_04D9, 32'hAAAA, 32'h33);
    check("byp_count3", issue_count, 3);
    rs_pkt[0].valid = 1'b0;
    cdb_valid = '0;
    step();
    check("byp_count4", issue_count, 4);
    check("byp_drain", fu_out[0].valid, 0);
    fu_ready = '0;

    // back-pressure on lane1
    rs_pkt[1] = make_rs(32'h0000_05A3, 6'd5, 6'd7);
    step();
    check_pkt(1, "bp_first", 32'h0000_05A3, 32'h1234, 32'hAAAA);
    rs_pkt[1] = make_rs(32'h0000_06B6, 6'd9, 6'd5);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp_ready_c%0d", c), rs_ready[1], 0);
      step();
      check($sformatf("bp_hold_pc_c%0d", c), fu_out[1].pc, 32'h0000_05A3);
      check($sformatf("bp_hold_v_c%0d", c), fu_out[1].valid, 1);
    end
    check("bp_count_hold", issue_count, 4);
    fu_ready = 3'b010;
    #1;
    check("bp_release_ready", rs_ready[1], 1);
    step();
    check_pkt(1, "bp_new", 32'h0000_06B6, 32'h9999, 32'h1234);
    check("bp_count5", issue_count, 5);
    rs_pkt[1].valid = 1'b0;
    step();
    check("bp_count6", issue_count, 6);
    check("sat_pre", count_sat, 6);
    fu_ready = '0;

    // full throughput on all lanes for 10 cycles
    fu_ready = 3'b111;
    for (int c = 0; c < 10; c++) begin
      for (int l = 0; l < WAYS; l++) begin
        logic [31:0] pc;
        pc = 32'h1000 + c * 32'h40 + l * 32'h13;
        rs_pkt[l] = make_rs(pc, 6'(c + 1), 6'(l + 10));
        exp_q.push_back(pc);
      end
      #1;
      check($sformatf("thru_ready_c%0d", c), rs_ready, 3'b111);
      step();
      for (int l = 0; l < WAYS; l++) begin
        check($sformatf("thru_pc_c%0d_l%0d", c, l), fu_out[l].pc, exp_q.pop_front());
        check($sformatf("thru_rs1_c%0d_l%0d", c, l), fu_out[l].rs1_value, prf_val(c + 1));
      end
    end
    rs_pkt = '0;
    step();
    check("thru_count", issue_count, 36);
    check("thru_drain", {fu_out[2].valid, fu_out[1].valid, fu_out[0].valid}, 3'b000);
    check("thru_count_sat", count_sat, 15);
    fu_ready = '0;

    // squash with lanes 0 and 2 full, lane0 handshaking in the squash cycle
    rs_pkt[0] = make_rs(32'h0000_07C1, 6'd5, 6'd0);
    rs_pkt[2] = make_rs(32'h0000_08E2, 6'd7, 6'd0);
    step();
    check("sq_full", {fu_out[2].valid, fu_out[1].valid, fu_out[0].valid}, 3'b101);
    for (int l = 0; l < WAYS; l++) rs_pkt[l] = make_rs(32'h0000_09F0 + l, 6'd9, 6'd9);
    squash   = 1'b1;
    fu_ready = 3'b001;
    #1;
    check("sq_ready", rs_ready, 3'b000);
    step();
    check("sq_valid", {fu_out[2].valid, fu_out[1].valid, fu_out[0].valid}, 3'b000);
    check("sq_count", issue_count, 37);
    check("sq_payload_hold", fu_out[2].pc, 32'h0000_08E2);
    squash   = 1'b0;
    rs_pkt   = '0;
    fu_ready = '0;
    step();
    check("sq_after", {fu_out[2].valid, fu_out[1].valid, fu_out[0].valid}, 3'b000);
    check("sq_count_after", issue_count, 37);

    // reset with squash while a packet is held: everything cleared
    rs_pkt[1] = make_rs(32'h0000_0A55, 6'd5, 6'd7);
    step();
    check("rst2_full", fu_out[1].valid, 1);
    rs_pkt[1].valid = 1'b0;
    reset    = 1'b0;
    squash   = 1'b1;
    fu_ready = 3'b010;
    step();
    check("rst2_zero", {63'd0, |fu_out}, 0);
    check("rst2_count", issue_count, 0);
    check("rst2_count_sat", count_sat, 0);
    reset    = 1'b1;
    squash   = 1'b0;
    fu_ready = '0;

    // saturation: 20 handshakes on lane0
    fu_ready = 3'b001;
    for (int c = 0; c < 20; c++) begin
      rs_pkt[0] = make_rs(32'h0000_0B00 + c * 4, 6'd5, 6'd7);
      step();
      if (c == 15) check("sat_reach", count_sat, 15);
    end
    rs_pkt = '0;
    step();
    check("sat_wide_count", issue_count, 20);
    check("sat_stop", count_sat, 15);
    fu_ready = '0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/issue_pipe.md
Name: issue_pipe

Overview:
Parametrised, registered successor to the combinational issue stage.
- Sits between the reservation station (RS) and the functional units (FUs).
- For each of WAYS lanes, accepts an RS_ISSUE_PACKET, reads operands from the physical register file, and forwards same-cycle CDB broadcasts (bypass).
- Registers the resulting ISSUE_FU_PACKET into a per-lane output slot that uses a valid/ready handshake toward the FU.
- Supports per-lane FU back-pressure, a global squash, and an issued-instruction statistics counter.

Parameters:
- WAYS, 3: number of issue lanes.
- XLEN, 32: operand width.
- N_PHYS_REG, 64: physical register count. PR_W = $clog2(N_PHYS_REG).
- N_CDB, 3: number of CDB broadcast ports used for bypass.
- ZERO_PR, 0: physical index that always reads 0.
- COUNT_W, 32: width of the issue statistics counter.

Ports:
- clock, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-low. reset==0 at a rising clock edge resets the block.
- squash, in, 1: branch mispredict flush.
- rs_in, in, WAYS x RS_ISSUE_PACKET: candidate per lane; lane request is rs_in[i].valid.
- rs_ready, out, WAYS: lane i can accept this cycle.
- physical_register, in, N_PHYS_REG x XLEN: register file read view.
- cdb_valid, in, N_CDB: CDB broadcast valid.
- cdb_pr_idx, in, N_CDB x PR_W: broadcast destination tag.
- cdb_value, in, N_CDB x XLEN: broadcast value.
- fu_out, out, WAYS x ISSUE_FU_PACKET: registered packet; fu_out[i].valid is the lane-valid bit.
- fu_ready, in, WAYS: FU i accepts fu_out[i] this cycle.
- issue_count, out, COUNT_W: saturating count of FU handshakes completed.

Behaviour:
Reset
- On reset==0 at a clock edge: every fu_out[i] is all-zeros (valid=0) and issue_count=0.
- rs_ready is combinational, so it reads 1 while the lanes are empty; accepts in the reset cycle are discarded.
- Reset mid-operation drops all held packets, with no handshake.

Per-lane slot (2 states)
- EMPTY (fu_out[i].valid=0) or FULL (fu_out[i].valid=1).
- rs_ready[i] = !squash && (!fu_out[i].valid || fu_ready[i]). This is combinational; the RS must not wait on it.
- Accept = rs_in[i].valid && rs_ready[i]. On accept, the slot loads the new packet at the next edge and stays or becomes FULL. Latency is exactly 1 cycle.
- FU handshake = fu_out[i].valid && fu_ready[i]. With no accept in the same cycle, the slot goes EMPTY next cycle. With an accept, the slot is back-to-back replaced (full throughput).
- FULL && !fu_ready[i]: the slot holds its packet unchanged and rs_ready[i]=0.
- When the slot is EMPTY, payload fields hold their last values; only valid is cleared.
- Lanes are fully independent; there is no compaction or cross-lane reordering.

Payload
- All control fields are copied field-for-field: NPC, PC, opa/opb_select, op_sel, fu_sel→fu_select, alu/mult_func, inst, pr_idx, ar_idx, rob_idx, rd_mem, wr_mem, cond/uncond_branch, halt, illegal, csr_op.

Operand read (for each of reg1_pr_idx and reg2_pr_idx, evaluated in the accept cycle)
- idx == ZERO_PR → 0.
- Otherwise, if any k has cdb_valid[k] && cdb_pr_idx[k]==idx → cdb_value[k]. If several CDB ports match, the lowest k wins.
- Otherwise → physical_register[idx].
- Operands are captured at accept and are not re-bypassed while the slot holds.

Squash
- squash=1 forces rs_ready=0 in that cycle.
- At the next edge all slots go EMPTY, regardless of fu_ready. A handshake that fires in the squash cycle still counts toward issue_count.
- squash and reset asserted together: reset dominates; the result is the same (all EMPTY).

issue_count
- Each edge adds the number of lanes that completed an FU handshake in that cycle, from 0 to WAYS.
- Saturates at 2^COUNT_W-1 and never wraps.

Test Plan:
- Reset and single issue: reset low for 2 cycles, then reset=1; lane0 sends reg1=5, reg2=0 with physical_register[5]=0x1234. Required: fu_out[0].valid=1 one cycle later, rs1_value=0x1234, rs2_value=0. After fu_ready[0]=1, issue_count=1.
- Bypass priority: reg1=7, physical_register[7]=0xAAAA, cdb0=(7,0x11), cdb2=(7,0x22) in the same cycle. Required: rs1_value=0x11. With cdb_valid=0, rs1_value=0xAAAA.
- Back-pressure: lane1 FULL with fu_ready[1]=0 for 3 cycles while rs_in[1].valid=1. Required: rs_ready[1]=0 and fu_out[1] stable for 3 cycles. On the 4th cycle, fu_ready=1 → the new packet appears on the next edge and count increments by 1.
- Full throughput: all 3 lanes have fu_ready=1 and valid inputs for 10 cycles. Required: rs_ready=3'b111 throughout and issue_count=30 after drain.
- Squash: lanes 0 and 2 FULL, fu_ready=0, squash=1 with new rs inputs. Required: rs_ready=0 in that cycle and all valid=0 next cycle. With fu_ready[0]=1 during squash, count increments by 1.
- Saturation: COUNT_W=4, run 20 handshakes. Required: issue_count stops at 15.
